// File: rtl/sram_vga_scanout.sv
// SRAM-backed 640x480 VGA scanout: fetches one RGB565 word per 25 MHz pixel and expands it to RGB888.
// Optional define FRAME_SWAP_EN adds a frame_sel input choosing between two frame bases.
module sram_vga_scanout #(
    parameter int H_VIS  = 640,
    parameter int V_VIS  = 480,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic        CLOCK_50,
    input  logic        reset,
`ifdef FRAME_SWAP_EN
    input  logic        frame_sel,
`endif
    output logic [19:0] sram_ADDR,
    input  logic [15:0] sram_DQ,
    output logic        sram_CE_N,
    output logic        sram_OE_N,
    output logic        sram_WE_N,
    output logic        sram_LB_N,
    output logic        sram_UB_N,
    output logic        vga_out_CLK,
    output logic        vga_out_HS,
    output logic        vga_out_VS,
    output logic        vga_out_BLANK,
    output logic        vga_out_SYNC,
    output logic [7:0]  vga_out_R,
    output logic [7:0]  vga_out_G,
    output logic [7:0]  vga_out_B,
    output logic        frame_done
);

    typedef logic [9:0] cnt_t;

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam cnt_t H_VIS_C = cnt_t'(H_VIS);
    localparam cnt_t V_VIS_C = cnt_t'(V_VIS);
    localparam cnt_t H_LAST  = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_LAST  = cnt_t'(V_TOTAL - 1);
    localparam cnt_t HS_BEG  = cnt_t'(H_VIS + H_FP);
    localparam cnt_t HS_END  = cnt_t'(H_VIS + H_FP + H_SYNC);
    localparam cnt_t VS_BEG  = cnt_t'(V_VIS + V_FP);
    localparam cnt_t VS_END  = cnt_t'(V_VIS + V_FP + V_SYNC);
    localparam cnt_t HV_LAST = cnt_t'(H_VIS - 1);
    localparam cnt_t VV_LAST = cnt_t'(V_VIS - 1);

    localparam logic [19:0] BASE_A = 20'h00000;
    localparam logic [19:0] BASE_B = 20'h4B000;

    logic        phase;
    logic        run;
    cnt_t        hcnt;
    cnt_t        vcnt;
    logic [19:0] addr;
    logic [19:0] addr_last;
    logic [23:0] rgb;
    logic        hs;
    logic        vs;
    logic        blank;

    logic        tick;
    logic        visible;
    logic        line_end;
    logic        frame_end;
    logic        hs_now;
    logic        vs_now;
    logic [19:0] sel_base;

`ifdef FRAME_SWAP_EN
    assign sel_base = frame_sel ? BASE_B : BASE_A;
`else
    assign sel_base = BASE_A;
`endif

    function automatic logic [23:0] rgb565_to_888(input logic [15:0] p);
        return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
    endfunction

    assign tick      = phase;
    assign visible   = (hcnt < H_VIS_C) && (vcnt < V_VIS_C);
    assign line_end  = (hcnt == H_LAST);
    assign frame_end = line_end && (vcnt == V_LAST);
    assign hs_now    = !((hcnt >= HS_BEG) && (hcnt < HS_END));
    assign vs_now    = !((vcnt >= VS_BEG) && (vcnt < VS_END));

    // Timing generator and fetch address; frame_sel is only looked at when the address reloads.
    always_ff @(posedge CLOCK_50) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values of the others.
        if (reset) begin
            phase     <= 1'b0;
            run       <= 1'b0;
            hcnt      <= '0;
            vcnt      <= '0;
            addr      <= sel_base;
            addr_last <= '0;
        end else begin
            run   <= 1'b1;
            phase <= ~phase;
            if (tick) begin
                hcnt <= line_end ? '0 : hcnt + 10'd1;
                if (line_end)
                    vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 10'd1;
                if (frame_end)
                    addr <= sel_base;
                else if (visible)
                    addr <= addr + 20'd1;
                if (visible)
                    addr_last <= addr;
            end
        end
    end

    // Output pipeline: pixel data and syncs share one tick of latency.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            rgb   <= '0;
            hs    <= 1'b1;
            vs    <= 1'b1;
            blank <= 1'b0;
        end else if (tick) begin
            rgb   <= visible ? rgb565_to_888(sram_DQ) : 24'h000000;
            hs    <= hs_now;
            vs    <= vs_now;
            blank <= visible;
        end
    end

    // Between visible pixels the bus keeps the last fetched address instead of the pre-incremented one.
    assign sram_ADDR = (run && visible) ? addr : addr_last;

    assign sram_CE_N = ~run;
    assign sram_OE_N = ~run;
    assign sram_LB_N = ~run;
    assign sram_UB_N = ~run;
    assign sram_WE_N = 1'b1;

    assign vga_out_CLK   = phase;
    assign vga_out_HS    = hs;
    assign vga_out_VS    = vs;
    assign vga_out_BLANK = blank;
    assign vga_out_SYNC  = 1'b0;
    assign vga_out_R     = blank ? rgb[23:16] : 8'h00;
    assign vga_out_G     = blank ? rgb[15:8]  : 8'h00;
    assign vga_out_B     = blank ? rgb[7:0]   : 8'h00;

    assign frame_done = tick && (hcnt == HV_LAST) && (vcnt == VV_LAST);

endmodule
